// File: rtl/prog_loader.sv
// Program loader and run controller: streams host words into IM/DM, then runs the CPU until pc reaches HALT_PC.
// Optional build macro LOADER_CHECKSUM_EN adds a trailing per-block checksum word (CHK state).
module prog_loader #(
    parameter int          ADDR_W  = 10,
    parameter logic [31:0] HALT_PC = 32'd88
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       pc,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHK,
        S_RUN,
        S_HALT
    } state_t;

    state_t            state;
    logic              tgt_dm;
    logic [ADDR_W-1:0] cur_addr;
    logic [13:0]       remaining;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       csum;
`endif

    logic              accept;
    logic [1:0]        hdr_tgt;
    logic [13:0]       hdr_cnt;
    logic [ADDR_W-1:0] hdr_addr;

    assign in_ready = (state != S_RUN);
    assign accept   = in_valid && in_ready;
    assign hdr_tgt  = in_data[31:30];
    assign hdr_cnt  = in_data[29:16];
    assign hdr_addr = in_data[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tgt_dm    <= 1'b0;
            cur_addr  <= '0;
            remaining <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            im_we <= 1'b0;
            dm_we <= 1'b0;
            case (state)
                // HALT accepts headers exactly like IDLE; done lives in its own flop so it survives loads
                S_IDLE, S_HALT: begin
                    if (accept) begin
                        unique case (hdr_tgt)
                            2'b00, 2'b01: begin
                                tgt_dm    <= hdr_tgt[0];
                                cur_addr  <= hdr_addr;
                                remaining <= hdr_cnt;
`ifdef LOADER_CHECKSUM_EN
                                csum      <= '0;
`endif
                                if (hdr_cnt != 14'd0) begin
                                    state <= S_LOAD;
                                end else begin
`ifdef LOADER_CHECKSUM_EN
                                    state <= S_CHK;
`else
                                    state <= S_IDLE;
`endif
                                end
                            end
                            2'b10: begin
                                state   <= S_RUN;
                                cpu_rst <= 1'b0;
                                done    <= 1'b0;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (tgt_dm) begin
                            dm_we    <= 1'b1;
                            dm_addr  <= cur_addr;
                            dm_wdata <= in_data;
                        end else begin
                            im_we    <= 1'b1;
                            im_addr  <= cur_addr;
                            im_wdata <= in_data;
                        end
                        // address wraps naturally at 2^ADDR_W
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum      <= csum + in_data;
`endif
                        if (remaining == 14'd1) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= S_CHK;
`else
                            state <= S_IDLE;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        if (in_data != csum) begin
                            err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                end
`endif
                S_RUN: begin
                    if (pc == HALT_PC) begin
                        state   <= S_HALT;
                        cpu_rst <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: vector table, hand-written run/reset/checksum sequences, random blocks vs. memory model.
module tb_prog_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_data = '0;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       pc = '0;
    logic              cpu_rst;
    logic              done;
    logic              err;

    prog_loader #(.ADDR_W(ADDR_W), .HALT_PC(32'd88)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .pc(pc), .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] obs_im [int];
    logic [31:0] obs_dm [int];
    int          npulse   = 0;
    int          both_cnt = 0;

    always @(negedge clk) begin
        if (im_we && dm_we) both_cnt++;
        if (im_we) begin obs_im[int'(im_addr)] = im_wdata; npulse++; end
        if (dm_we) begin obs_dm[int'(dm_addr)] = dm_wdata; npulse++; end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    // Presents a word, waits (bounded) for in_ready, returns #1 after the accepting edge
    task automatic send(input logic [31:0] w);
        int waited = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            step();
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1 for word %0h", w);
            in_valid = 1'b0;
            return;
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    typedef struct {
        logic [31:0]       word;
        bit                ck_only;
        int                kind;    // 0 none, 1 IM write, 2 DM write
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [31:0] w, input bit c, input int k,
                                input int a, input logic [31:0] d);
        vec_t v;
        v.word = w; v.ck_only = c; v.kind = k; v.addr = ADDR_W'(a); v.data = d;
        return v;
    endfunction

    initial begin
        logic [31:0] exp_im [int];
        logic [31:0] exp_dm [int];
        int          nexp;

        // Reset state
        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_im_we", im_we, 0);
        chk("rst_dm_we", dm_we, 0);
        chk("rst_im_addr", im_addr, 0);
        chk("rst_dm_addr", dm_addr, 0);
        chk("rst_im_wdata", im_wdata, 0);
        chk("rst_dm_wdata", dm_wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        // Load blocks; every word is followed by an idle cycle (toggling valid)
        tbl.push_back(mk(32'h0003_0000, 0, 0, 0,    0));
        tbl.push_back(mk(32'h2010_0200, 0, 1, 0,    32'h2010_0200));
        tbl.push_back(mk(32'h2011_000C, 0, 1, 1,    32'h2011_000C));
        tbl.push_back(mk(32'h0000_0000, 0, 1, 2,    32'h0000_0000));
        tbl.push_back(mk(32'h4021_020C, 1, 0, 0,    0));
        tbl.push_back(mk(32'h4002_0080, 0, 0, 0,    0));
        tbl.push_back(mk(32'd55,        0, 2, 128,  32'd55));
        tbl.push_back(mk(32'd88,        0, 2, 129,  32'd88));
        tbl.push_back(mk(32'd143,       1, 0, 0,    0));
        tbl.push_back(mk(32'h4002_03FF, 0, 0, 0,    0));
        tbl.push_back(mk(32'hAAAA_5555, 0, 2, 1023, 32'hAAAA_5555));
        tbl.push_back(mk(32'h1234_5678, 0, 2, 0,    32'h1234_5678));
        tbl.push_back(mk(32'hBCDE_ABCD, 1, 0, 0,    0));
        foreach (tbl[i]) begin
            if (tbl[i].ck_only && !CK) continue;
            send(tbl[i].word);
            chk($sformatf("vec%0d_im_we", i), im_we, 32'(tbl[i].kind == 1));
            chk($sformatf("vec%0d_dm_we", i), dm_we, 32'(tbl[i].kind == 2));
            if (tbl[i].kind == 1) begin
                chk($sformatf("vec%0d_im_addr", i), im_addr, tbl[i].addr);
                chk($sformatf("vec%0d_im_wdata", i), im_wdata, tbl[i].data);
            end
            if (tbl[i].kind == 2) begin
                chk($sformatf("vec%0d_dm_addr", i), dm_addr, tbl[i].addr);
                chk($sformatf("vec%0d_dm_wdata", i), dm_wdata, tbl[i].data);
            end
            chk($sformatf("vec%0d_err", i), err, 0);
            idle(1);
            chk($sformatf("vec%0d_gap_we", i), {im_we, dm_we}, 0);
        end

        // GO, run until pc reaches 88
        pc = 0;
        send(32'h8000_0000);
        chk("go_cpu_rst", cpu_rst, 0);
        chk("go_done", done, 0);
        chk("go_in_ready", in_ready, 0);
        for (int p = 0; p < 88; p += 4) begin
            pc = p;
            step();
            chk($sformatf("run%0d_ready", p), in_ready, 0);
            chk($sformatf("run%0d_cpu_rst", p), cpu_rst, 0);
            chk($sformatf("run%0d_done", p), done, 0);
        end
        pc = 88;
        step();
        chk("halt_done", done, 1);
        chk("halt_cpu_rst", cpu_rst, 1);
        chk("halt_in_ready", in_ready, 1);
        pc = 0;

        // Loading while halted keeps done high; a second GO clears it
        send(32'h4001_0005);
        chk("halt_hdr_done", done, 1);
        send(32'h1234_0005);
        chk("halt_load_dm_we", dm_we, 1);
        chk("halt_load_dm_addr", dm_addr, 5);
        chk("halt_load_done", done, 1);
        chk("halt_load_cpu_rst", cpu_rst, 1);
        if (CK) send(32'h1234_0005);
        chk("halt_load_err", err, 0);
        send(32'h8000_0000);
        chk("go2_done", done, 0);
        chk("go2_cpu_rst", cpu_rst, 0);
        pc = 88;
        step();
        chk("halt2_done", done, 1);
        pc = 0;
        idle(1);

        // Reserved header sets err and is discarded
        send(32'hC000_0000);
        chk("rsv_err", err, 1);
        chk("rsv_we", {im_we, dm_we}, 0);
        chk("rsv_ready", in_ready, 1);
        idle(1);
        send(32'h4001_0007);
        chk("rsv_next_hdr_we", {im_we, dm_we}, 0);
        send(32'h0000_00A5);
        chk("rsv_next_dm_we", dm_we, 1);
        chk("rsv_next_dm_addr", dm_addr, 7);
        chk("rsv_next_dm_wdata", dm_wdata, 32'hA5);
        if (CK) send(32'h0000_00A5);
        idle(1);

        // Reset mid-LOAD abandons the block and clears err
        send(32'h0003_000A);
        send(32'h1111_1111);
        chk("midrst_first_im_we", im_we, 1);
        chk("midrst_first_im_addr", im_addr, 10);
        rst = 1'b1;
        #2;
        chk("midrst_err", err, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_im_we", im_we, 0);
        step();
        rst = 1'b0;
        step();
        send(32'h0001_0014);
        chk("midrst_hdr_no_we", {im_we, dm_we}, 0);
        send(32'h0000_0077);
        chk("midrst_im_we2", im_we, 1);
        chk("midrst_im_addr2", im_addr, 20);
        chk("midrst_im_wdata2", im_wdata, 32'h77);
        if (CK) send(32'h0000_0077);
        chk("midrst_err2", err, 0);
        idle(1);

`ifdef LOADER_CHECKSUM_EN
        // Checksum good, empty block, then bad checksum
        send(32'h4002_012C);
        send(32'd5);
        chk("ck_w0_addr", dm_addr, 300);
        chk("ck_w0_data", dm_wdata, 5);
        send(32'd7);
        chk("ck_w1_addr", dm_addr, 301);
        chk("ck_w1_data", dm_wdata, 7);
        send(32'd12);
        chk("ck_good_nowrite", {im_we, dm_we}, 0);
        chk("ck_good_err", err, 0);
        send(32'h4000_0000);
        send(32'd0);
        chk("ck_empty_err", err, 0);
        send(32'h4002_012C);
        send(32'd5);
        chk("ckbad_w0", {dm_we, dm_addr}, {1'b1, 10'd300});
        send(32'd7);
        chk("ckbad_w1", {dm_we, dm_addr}, {1'b1, 10'd301});
        send(32'd13);
        chk("ckbad_nowrite", {im_we, dm_we}, 0);
        chk("ckbad_err", err, 1);
        idle(1);
`endif

        // Random blocks against a memory-image model
        do_reset();
        obs_im.delete();
        obs_dm.delete();
        npulse   = 0;
        both_cnt = 0;
        nexp     = 0;
        for (int b = 0; b < 40; b++) begin
            int          tgt;
            int          cnt;
            int          addr;
            logic [31:0] sum;
            tgt  = $urandom_range(0, 1);
            cnt  = $urandom_range(1, 6);
            addr = ($urandom_range(0, 3) == 0) ? DEPTH - 3 + $urandom_range(0, 2)
                                               : $urandom_range(0, DEPTH - 1);
            send({(tgt != 0) ? 2'b01 : 2'b00, 14'(cnt), 16'(addr)});
            sum = '0;
            for (int k = 0; k < cnt; k++) begin
                logic [31:0] d;
                int          a;
                d = $urandom;
                a = (addr + k) % DEPTH;
                if (tgt != 0) exp_dm[a] = d;
                else          exp_im[a] = d;
                sum += d;
                nexp++;
                send(d);
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            end
            if (CK) send(sum);
        end
        idle(3);
        chk("rand_pulses", npulse, nexp);
        chk("rand_both_we", both_cnt, 0);
        chk("rand_err", err, 0);
        chk("rand_im_size", obs_im.size(), exp_im.size());
        chk("rand_dm_size", obs_dm.size(), exp_dm.size());
        foreach (exp_im[a]) begin
            logic [31:0] act;
            act = obs_im.exists(a) ? obs_im[a] : 'x;
            chk($sformatf("rand_im[%0d]", a), act, exp_im[a]);
        end
        foreach (exp_dm[a]) begin
            logic [31:0] act;
            act = obs_dm.exists(a) ? obs_dm[a] : 'x;
            chk($sformatf("rand_dm[%0d]", a), act, exp_dm[a]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
